// File: rtl/jtframe_i2s_rx.sv
// I2S receiver: recovers signed left/right samples from an asynchronous
// BCLK/LRCLK/DATA link and presents each stereo pair with a one-cycle strobe.
module jtframe_i2s_rx #(
    parameter int DW  = 16,
    parameter int TOW = 12
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i2s_bclk,
    input  logic          i2s_lrclk,
    input  logic          i2s_data,
    output logic [DW-1:0] left,
    output logic [DW-1:0] right,
    output logic          sample,
    output logic          locked,
    output logic          err
);

    typedef enum logic {
        SEEK = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam logic [5:0]     DW_C   = 6'(DW);
    localparam logic [5:0]     CNT_MX = 6'd63;
    localparam logic [TOW-1:0] TO_MAX = {TOW{1'b1}};

    // Synchroniser stages, bit order {data, ws, bclk}
    logic [2:0]    s1_q, s1_d;
    logic [2:0]    s2_q, s2_d;
    logic          bclk_h_q, bclk_h_d;

    // Registered edge-detect stage: ws/data travel alongside the BCLK rise
    logic          brise_q, brise_d;
    logic          ws_e_q, ws_e_d;
    logic          dat_e_q, dat_e_d;

    state_t        state_q, state_d;
    logic          seen_q, seen_d;
    logic          ws_prev_q, ws_prev_d;
    logic [5:0]    cnt_q, cnt_d;
    logic [DW-1:0] shift_q, shift_d;
    logic [DW-1:0] left_hold_q, left_hold_d;
    logic          left_ok_q, left_ok_d;
    logic [TOW-1:0] to_q, to_d;

    logic [DW-1:0] left_q, left_d;
    logic [DW-1:0] right_q, right_d;
    logic          sample_q, sample_d;
    logic          locked_q, locked_d;
    logic          err_q, err_d;

    logic [DW-1:0] shift_nx;
    logic [5:0]    cnt_nx;
    logic          ws_change;

    always_comb begin
        s1_d        = {i2s_data, i2s_lrclk, i2s_bclk};
        s2_d        = s1_q;
        bclk_h_d    = s2_q[0];
        brise_d     = s2_q[0] & ~bclk_h_q;
        ws_e_d      = s2_q[1];
        dat_e_d     = s2_q[2];

        state_d     = state_q;
        seen_d      = seen_q;
        ws_prev_d   = ws_prev_q;
        cnt_d       = cnt_q;
        shift_d     = shift_q;
        left_hold_d = left_hold_q;
        left_ok_d   = left_ok_q;
        to_d        = to_q;
        left_d      = left_q;
        right_d     = right_q;
        sample_d    = 1'b0;
        locked_d    = locked_q;
        err_d       = 1'b0;

        // Bits past the first DW of a slot are counted but not stored
        shift_nx  = (cnt_q < DW_C) ? {shift_q[DW-2:0], dat_e_q} : shift_q;
        cnt_nx    = (cnt_q == CNT_MX) ? cnt_q : cnt_q + 6'd1;
        ws_change = (ws_e_q != ws_prev_q);

        if (brise_q) begin
            to_d      = '0;
            ws_prev_d = ws_e_q;
            seen_d    = 1'b1;
            case (state_q)
                SEEK: begin
                    // The first ws change only arms framing; the slot before it is partial
                    if (seen_q && ws_change) begin
                        state_d   = RUN;
                        cnt_d     = '0;
                        shift_d   = '0;
                        left_ok_d = 1'b0;
                    end
                end
                RUN: begin
                    if (ws_change) begin
                        cnt_d   = '0;
                        shift_d = '0;
                        if (cnt_q >= DW_C - 6'd1) begin
                            if (!ws_prev_q) begin
                                left_hold_d = shift_nx;
                                left_ok_d   = 1'b1;
                            end else if (left_ok_q) begin
                                left_d    = left_hold_q;
                                right_d   = shift_nx;
                                sample_d  = 1'b1;
                                locked_d  = 1'b1;
                                left_ok_d = 1'b0;
                            end
                        end else begin
                            err_d     = 1'b1;
                            left_ok_d = 1'b0;
                        end
                    end else begin
                        cnt_d   = cnt_nx;
                        shift_d = shift_nx;
                    end
                end
                default: state_d = SEEK;
            endcase
        end else if (to_q == TO_MAX) begin
            // BCLK lost: drop lock but keep the last samples on the outputs
            locked_d  = 1'b0;
            left_ok_d = 1'b0;
            seen_d    = 1'b0;
            state_d   = SEEK;
        end else begin
            to_d = to_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_q        <= '0;
            s2_q        <= '0;
            bclk_h_q    <= 1'b0;
            brise_q     <= 1'b0;
            ws_e_q      <= 1'b0;
            dat_e_q     <= 1'b0;
            state_q     <= SEEK;
            seen_q      <= 1'b0;
            ws_prev_q   <= 1'b0;
            cnt_q       <= '0;
            shift_q     <= '0;
            left_hold_q <= '0;
            left_ok_q   <= 1'b0;
            to_q        <= '0;
            left_q      <= '0;
            right_q     <= '0;
            sample_q    <= 1'b0;
            locked_q    <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            s1_q        <= s1_d;
            s2_q        <= s2_d;
            bclk_h_q    <= bclk_h_d;
            brise_q     <= brise_d;
            ws_e_q      <= ws_e_d;
            dat_e_q     <= dat_e_d;
            state_q     <= state_d;
            seen_q      <= seen_d;
            ws_prev_q   <= ws_prev_d;
            cnt_q       <= cnt_d;
            shift_q     <= shift_d;
            left_hold_q <= left_hold_d;
            left_ok_q   <= left_ok_d;
            to_q        <= to_d;
            left_q      <= left_d;
            right_q     <= right_d;
            sample_q    <= sample_d;
            locked_q    <= locked_d;
            err_q       <= err_d;
        end
    end

    assign left   = left_q;
    assign right  = right_q;
    assign sample = sample_q;
    assign locked = locked_q;
    assign err    = err_q;

endmodule

// File: tb/tb_jtframe_i2s_rx.sv
// Bench for jtframe_i2s_rx: drives I2S slots bit by bit and checks the
// outputs every cycle against a slot-level model of the receiver.
module tb_jtframe_i2s_rx;

    localparam int DW  = 16;
    localparam int TOW = 12;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          i2s_bclk = 1'b0;
    logic          i2s_lrclk = 1'b0;
    logic          i2s_data = 1'b0;
    logic [DW-1:0] left, right;
    logic          sample, locked, err;

    jtframe_i2s_rx #(.DW(DW), .TOW(TOW)) dut (
        .clk       (clk),
        .rst       (rst),
        .i2s_bclk  (i2s_bclk),
        .i2s_lrclk (i2s_lrclk),
        .i2s_data  (i2s_data),
        .left      (left),
        .right     (right),
        .sample    (sample),
        .locked    (locked),
        .err       (err)
    );

    // clk 50 MHz, BCLK = clk/16
    always #10 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    int n_checks = 0;
    int n_fail   = 0;
    int n_strobe = 0;
    int n_err    = 0;
    int last_rise = 0;

    typedef struct packed {
        logic          is_err;
        logic [DW-1:0] l;
        logic [DW-1:0] r;
        logic [31:0]   cyc;
    } ev_t;

    ev_t           exp_q[$];
    logic          m_armed = 1'b0;
    logic          m_left_ok = 1'b0;
    logic [DW-1:0] m_hold = '0;
    logic [DW-1:0] cur_left = '0;
    logic [DW-1:0] cur_right = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    // ---------------- slot-level model ----------------
    task automatic model_reset();
        exp_q.delete();
        m_armed   = 1'b0;
        m_left_ok = 1'b0;
        cur_left  = '0;
        cur_right = '0;
    endtask

    task automatic model_timeout();
        m_armed   = 1'b0;
        m_left_ok = 1'b0;
    endtask

    task automatic model_slot_end(input logic ws, input int len, input logic [DW-1:0] word, input int rcyc);
        ev_t ev;
        if (!m_armed) begin
            m_armed = 1'b1;
            return;
        end
        if (len >= DW) begin
            if (ws == 1'b0) begin
                m_hold    = word;
                m_left_ok = 1'b1;
            end else if (m_left_ok) begin
                ev = '{is_err: 1'b0, l: m_hold, r: word, cyc: 32'(rcyc)};
                exp_q.push_back(ev);
                m_left_ok = 1'b0;
            end
        end else begin
            ev = '{is_err: 1'b1, l: '0, r: '0, cyc: 32'(rcyc)};
            exp_q.push_back(ev);
            m_left_ok = 1'b0;
        end
    endtask

    // ---------------- compare process ----------------
    always @(negedge clk) begin
        ev_t ev;
        if (!rst) begin
            if (sample === 1'b1 || err === 1'b1) begin
                n_strobe += int'(sample === 1'b1);
                n_err    += int'(err === 1'b1);
                if (exp_q.size() == 0) begin
                    check("unexpected_event", {30'b0, sample, err}, 32'd0);
                end else begin
                    ev = exp_q.pop_front();
                    check("event_kind", {30'b0, sample, err}, ev.is_err ? 32'd1 : 32'd2);
                    check("event_latency", cyc - int'(ev.cyc), 32'd4);
                    if (!ev.is_err) begin
                        cur_left  = ev.l;
                        cur_right = ev.r;
                    end
                end
            end
            check("left_value", 32'(left), 32'(cur_left));
            check("right_value", 32'(right), 32'(cur_right));
        end
    end

    // ---------------- drivers ----------------
    task automatic idle(input int n);
        repeat (n) step();
    endtask

    // One slot, MSB first; the last bit already carries the next slot's ws.
    task automatic send_slot(input logic ws, input int len, input logic [DW-1:0] word,
                             input logic next_ws, input int rst_bit);
        for (int i = 0; i < len; i++) begin
            i2s_lrclk = (i == len - 1) ? next_ws : ws;
            i2s_data  = (i < DW) ? word[DW-1-i] : 1'($urandom_range(0, 1));
            repeat (4) step();
            i2s_bclk  = 1'b1;
            last_rise = cyc;
            if (i == len - 1 && next_ws != ws)
                model_slot_end(ws, len, word, cyc);
            repeat (8) step();
            i2s_bclk = 1'b0;
            if (i == rst_bit) begin
                rst = 1'b1;
                model_reset();
                repeat (3) step();
                check("rst_mid_left", 32'(left), 32'd0);
                check("rst_mid_right", 32'(right), 32'd0);
                check("rst_mid_locked", 32'(locked), 32'd0);
                check("rst_mid_sample", 32'(sample), 32'd0);
                rst = 1'b0;
                step();
            end else begin
                repeat (4) step();
            end
        end
    endtask

    task automatic send_frame(input logic [DW-1:0] l, input logic [DW-1:0] r,
                              input int len, input int rst_right_bit);
        send_slot(1'b0, len, l, 1'b1, -1);
        send_slot(1'b1, len, r, 1'b0, rst_right_bit);
    endtask

    task automatic preamble();
        send_slot(1'b1, 4, '0, 1'b0, -1);
    endtask

    task automatic settle();
        idle(12);
        check("pending_events", exp_q.size(), 32'd0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int s0, e0, waited, lat;

        // Reset with random line activity
        rst = 1'b1;
        for (int i = 0; i < 5; i++) begin
            i2s_bclk  = 1'($urandom_range(0, 1));
            i2s_lrclk = 1'($urandom_range(0, 1));
            i2s_data  = 1'($urandom_range(0, 1));
            step();
        end
        check("reset_left", 32'(left), 32'd0);
        check("reset_right", 32'(right), 32'd0);
        check("reset_sample", 32'(sample), 32'd0);
        check("reset_locked", 32'(locked), 32'd0);
        check("reset_err", 32'(err), 32'd0);
        check("reset_state_seek", 32'(dut.state_q), 32'd0);
        i2s_bclk = 1'b0; i2s_lrclk = 1'b0; i2s_data = 1'b0;
        step();
        rst = 1'b0;
        model_reset();
        idle(20);

        // Nominal 32-bit frame
        s0 = n_strobe; e0 = n_err;
        preamble();
        send_frame(16'h8001, 16'h7FFE, 32, -1);
        settle();
        check("nominal_strobes", n_strobe - s0, 32'd1);
        check("nominal_errs", n_err - e0, 32'd0);
        check("nominal_left", 32'(left), 32'h8001);
        check("nominal_right", 32'(right), 32'h7FFE);
        check("nominal_locked", 32'(locked), 32'd1);
        idle(30);

        // Exact-width slots, then short slots
        s0 = n_strobe; e0 = n_err;
        send_frame(16'hA5A5, 16'h5A5A, 16, -1);
        settle();
        check("exact_strobes", n_strobe - s0, 32'd1);
        check("exact_left", 32'(left), 32'hA5A5);
        check("exact_right", 32'(right), 32'h5A5A);
        s0 = n_strobe; e0 = n_err;
        send_frame(16'hFF00, 16'h00FF, 8, -1);
        send_frame(16'h1200, 16'h3400, 8, -1);
        settle();
        check("short_strobes", n_strobe - s0, 32'd0);
        check("short_errs", n_err - e0, 32'd4);
        check("short_hold_left", 32'(left), 32'hA5A5);
        check("short_hold_right", 32'(right), 32'h5A5A);
        check("short_locked", 32'(locked), 32'd1);

        // BCLK loss
        waited = 0;
        while (locked !== 1'b0 && waited < 4300) begin
            step();
            waited++;
        end
        lat = cyc - last_rise;
        check("timeout_locked", 32'(locked), 32'd0);
        check("timeout_latency_ok", 32'(lat >= 4096 && lat <= 4100), 32'd1);
        check("timeout_state_seek", 32'(dut.state_q), 32'd0);
        check("timeout_hold_left", 32'(left), 32'hA5A5);
        model_timeout();
        s0 = n_strobe;
        preamble();
        send_frame(16'h0001, 16'hFFFF, 32, -1);
        settle();
        check("restart_strobes", n_strobe - s0, 32'd1);
        check("restart_left", 32'(left), 32'h0001);
        check("restart_right", 32'(right), 32'hFFFF);
        check("restart_locked", 32'(locked), 32'd1);

        // Slots longer than the 6-bit counter range
        send_frame(16'hC3C3, 16'h3C3C, 70, -1);
        settle();
        check("long_left", 32'(left), 32'hC3C3);
        check("long_right", 32'(right), 32'h3C3C);

        // Start mid right slot after reset
        s0 = n_strobe;
        send_frame(16'hAAAA, 16'hBBBB, 32, 10);
        send_frame(16'h1234, 16'h5678, 32, -1);
        settle();
        check("midstart_first_left", 32'(left), 32'h1234);
        check("midstart_first_right", 32'(right), 32'h5678);
        send_frame(16'h9ABC, 16'hDEF0, 32, -1);
        settle();
        check("midstart_strobes", n_strobe - s0, 32'd2);
        check("midstart_left", 32'(left), 32'h9ABC);
        check("midstart_right", 32'(right), 32'hDEF0);

        // Reset during the right slot of a frame
        s0 = n_strobe;
        send_frame(16'h1111, 16'h2222, 32, 20);
        settle();
        check("rstmid_no_strobe", n_strobe - s0, 32'd0);
        check("rstmid_left_zero", 32'(left), 32'd0);
        send_frame(16'h3333, 16'h4444, 32, -1);
        settle();
        check("rstmid_strobes", n_strobe - s0, 32'd1);
        check("rstmid_left", 32'(left), 32'h3333);
        check("rstmid_right", 32'(right), 32'h4444);
        check("rstmid_locked", 32'(locked), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1_500_000;
        $display("FAIL watchdog: simulation did not finish, %0d failures so far", n_fail);
        $fatal(1, "watchdog expired");
    end

endmodule
